// File: rtl/tmr_vote_ctrl.sv
// rtl/tmr_vote_ctrl.sv - TMR majority-vote sequencing controller with fault retirement
//
// Votes three redundant W-bit channels into one output word, with a one-cycle
// valid/ready pipeline. Each channel has a counter of consecutive strikes.
// A channel is retired after FAULT_THRESH strikes in a row.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_ready, a, b, c input handshake and the three channel words
//   out_valid, out_ready, f     output handshake and the voted word
//   mismatch                    one-cycle pulse: the last accepted word disagreed
//   err_a, err_b, err_c         sticky per-channel retirement flags
//   fail                        two or more channels are retired
//   clear_faults                synchronous clear of strikes, err flags and state
module tmr_vote_ctrl #(
  parameter int W            = 8,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f,
  output logic         mismatch,
  output logic         err_a,
  output logic         err_b,
  output logic         err_c,
  output logic         fail,
  input  logic         clear_faults
);

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_DEGRADED = 2'd1;
  localparam logic [1:0] ST_FAILED   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     f_q;
  logic             out_valid_q, mismatch_q;
  logic             err_a_q, err_b_q, err_c_q;
  logic             err_a_d, err_b_d, err_c_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_c_d;

  logic         accept;
  logic [W-1:0] maj, vote;
  logic         word_mismatch;

  // The operating state is simply a function of how many channels are retired.
  function automatic logic [1:0] state_of(input logic ea, input logic eb, input logic ec);
    logic [1:0] n;
    n = {1'b0, ea} + {1'b0, eb} + {1'b0, ec};
    case (n)
      2'd0:    state_of = ST_NORMAL;
      2'd1:    state_of = ST_DEGRADED;
      default: state_of = ST_FAILED;
    endcase
  endfunction

  // A strike saturates at the counter ceiling; any matching word clears the run.
  function automatic logic [CNT_W-1:0] strike(input logic [CNT_W-1:0] cnt, input logic differ);
    if (!differ)             strike = '0;
    else if (cnt == CNT_MAX) strike = cnt;
    else                     strike = cnt + 1'b1;
  endfunction

  assign in_ready = (state_q != ST_FAILED) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    maj  = (a & b) | (b & c) | (a & c);
    vote = maj;
    word_mismatch = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        word_mismatch = (a != maj) || (b != maj) || (c != maj);
      end
      ST_DEGRADED: begin
        // Pass through the first healthy channel; flag disagreement between the two survivors.
        if (!err_a_q) begin
          vote          = a;
          word_mismatch = !err_b_q ? (a != b) : (a != c);
        end else begin
          vote          = b;
          word_mismatch = (b != c);
        end
      end
      default: begin
        vote          = maj;
        word_mismatch = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    err_a_d = err_a_q;
    err_b_d = err_b_q;
    err_c_d = err_c_q;
    if (clear_faults) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
      err_a_d = 1'b0;
      err_b_d = 1'b0;
      err_c_d = 1'b0;
    end else if (accept && (state_q == ST_NORMAL)) begin
      cnt_a_d = strike(cnt_a_q, a != maj);
      cnt_b_d = strike(cnt_b_q, b != maj);
      cnt_c_d = strike(cnt_c_q, c != maj);
      if (cnt_a_d >= THRESH) err_a_d = 1'b1;
      if (cnt_b_d >= THRESH) err_b_d = 1'b1;
      if (cnt_c_d >= THRESH) err_c_d = 1'b1;
    end
    state_d = state_of(err_a_d, err_b_d, err_c_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      f_q         <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      err_c_q     <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      cnt_c_q     <= '0;
    end else begin
      state_q    <= state_d;
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      err_c_q    <= err_c_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      cnt_c_q    <= cnt_c_d;
      mismatch_q <= accept && word_mismatch;
      if (accept) begin
        f_q         <= vote;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign f         = f_q;
  assign out_valid = out_valid_q;
  assign mismatch  = mismatch_q;
  assign err_a     = err_a_q;
  assign err_b     = err_b_q;
  assign err_c     = err_c_q;
  assign fail      = (state_q == ST_FAILED);

endmodule
